// File: rtl/ascon_deserializer_if.sv
// Result-side handshake bundle of the Ascon serial capture stage.
// The deserializer drives the result (master); bus-side logic accepts it (slave).
interface ascon_deserializer_if #(
  parameter int Y = 200,
  parameter int T = 128
);
  logic         out_ready_i;
  logic [Y-1:0] out_data_o;
  logic [T-1:0] out_tag_o;
  logic         out_valid_o;
  logic         tag_ok_o;

  modport master (
    input  out_ready_i,
    output out_data_o, out_tag_o, out_valid_o, tag_ok_o
  );

  modport slave (
    output out_ready_i,
    input  out_data_o, out_tag_o, out_valid_o, tag_ok_o
  );
endinterface

// File: rtl/ascon_deserializer.sv
// Captures the LSB-first payload/tag streams of the serial Ascon wrapper into
// parallel words, verifies the tag in decrypt mode and offers the result on valid/ready.
//
// state    | meaning
// IDLE     | waiting for core_ready_i rising; latch expected tag and mode
// SHIFT    | sampling one payload/tag bit per cycle, cnt = bit index
// DONE     | result held on out_valid_o until accepted
// WAIT_LOW | result taken while core_ready_i still high; wait for it to drop
module ascon_deserializer #(
  parameter int Y = 200,
  parameter int T = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         core_ready_i,
  input  logic         ser_data_i,
  input  logic         ser_tag_i,
  input  logic [T-1:0] exp_tag_i,
  input  logic         check_en_i,
  output logic         busy_o,
  output logic         abort_o,
  ascon_deserializer_if.master out_if
);
  localparam int N  = (Y > T) ? Y : T;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_LOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [Y-1:0]  data_q, data_d, data_sh;
  logic [T-1:0]  tag_q, tag_d, tag_sh;
  logic [T-1:0]  exp_tag_q, exp_tag_d;
  logic          check_en_q, check_en_d;
  logic          tag_ok_q, tag_ok_d;
  logic          abort_q, abort_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      exp_tag_q  <= '0;
      check_en_q <= 1'b0;
      tag_ok_q   <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      exp_tag_q  <= exp_tag_d;
      check_en_q <= check_en_d;
      tag_ok_q   <= tag_ok_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    tag_d      = tag_q;
    exp_tag_d  = exp_tag_q;
    check_en_d = check_en_q;
    tag_ok_d   = tag_ok_q;
    abort_d    = 1'b0;

    // Registers with this cycle's bit merged in; indices past Y/T never match.
    data_sh = data_q;
    tag_sh  = tag_q;
    for (int i = 0; i < Y; i++) begin
      if (cnt_q == CW'(i)) data_sh[i] = ser_data_i;
    end
    for (int i = 0; i < T; i++) begin
      if (cnt_q == CW'(i)) tag_sh[i] = ser_tag_i;
    end

    case (state_q)
      IDLE: begin
        if (core_ready_i) begin
          state_d    = SHIFT;
          cnt_d      = '0;
          exp_tag_d  = exp_tag_i;
          check_en_d = check_en_i;
          data_d     = '0;
          tag_d      = '0;
          tag_ok_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (!core_ready_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          data_d  = '0;
          tag_d   = '0;
          abort_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          data_d = data_sh;
          tag_d  = tag_sh;
          if (cnt_q == LAST) begin
            state_d  = DONE;
            cnt_d    = '0;
            tag_ok_d = check_en_q && (tag_sh == exp_tag_q);
            // Plaintext is never released when authentication fails.
            if (check_en_q && (tag_sh != exp_tag_q)) data_d = '0;
          end
        end
      end
      DONE: begin
        if (out_if.out_ready_i) state_d = core_ready_i ? WAIT_LOW : IDLE;
      end
      WAIT_LOW: begin
        if (!core_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_if.out_data_o  = data_q;
  assign out_if.out_tag_o   = tag_q;
  assign out_if.out_valid_o = (state_q == DONE);
  assign out_if.tag_ok_o    = tag_ok_q;
  assign busy_o             = (state_q == SHIFT);
  assign abort_o            = abort_q;
endmodule

// File: doc/ascon_deserializer.md
# ascon_deserializer

Downstream capture stage for the serial Ascon wrapper. Collects the LSB-first bit streams on `output_dataxSO` and `tagxSO` once `ascon_readyxSO` rises, and assembles them into parallel ciphertext/plaintext and tag words. Compares the received tag against an expected tag in decrypt mode, and withholds plaintext on mismatch. Presents the result on a valid/ready handshake to the bus-side logic.

## Interface
- `Y`, 200, payload length in bits; must equal the wrapper's `y`.
- `T`, 128, tag length in bits.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high; clock `clk`.
- `core_ready_i`  in  1  wrapper `ascon_readyxSO` (level).
- `ser_data_i`  in  1  wrapper `output_dataxSO`.
- `ser_tag_i`  in  1  wrapper `tagxSO`.
- `exp_tag_i`  in  T  expected tag for decrypt verification.
- `check_en_i`  in  1  1 = decrypt, verify tag.
- `out_ready_i`  in  1  consumer accepts result.
- `out_data_o`  out  Y  assembled payload; bit n = n-th received bit.
- `out_tag_o`  out  T  assembled tag; bit n = n-th received bit.
- `out_valid_o`  out  1  result available.
- `tag_ok_o`  out  1  1 = verification passed; valid only with `out_valid_o`.
- `busy_o`  out  1  high in SHIFT.
- `abort_o`  out  1  one-cycle pulse on capture abort.

## Operation
- States: IDLE, SHIFT, DONE, WAIT_LOW.
- Constant `N = max(Y,T)`. Capture counter `cnt` is `$clog2(N+1)` bits wide.
- IDLE:
  - On `core_ready_i`=1, go to SHIFT with `cnt`=0.
  - Same edge: latch `exp_tag_i` and `check_en_i`; clear `out_data_o`, `out_tag_o`, `tag_ok_o`.
- SHIFT, each cycle:
  - If `cnt`<Y, write `ser_data_i` to data bit `cnt`.
  - If `cnt`<T, write `ser_tag_i` to tag bit `cnt`.
  - Increment `cnt`.
  - After the cycle with `cnt`=N-1, go to DONE.
- SHIFT abort: if `core_ready_i`=0 in any SHIFT cycle, drop that cycle's bits and go to IDLE. Clear the data/tag registers and pulse `abort_o` the next cycle.
- Entry to DONE: `tag_ok_o` = latched `check_en` & (assembled tag == latched `exp_tag`).
  - If latched `check_en`=1 and the tags mismatch, force `out_data_o` to 0. Plaintext is never released on auth failure.
  - If latched `check_en`=0, `tag_ok_o`=0 and the data is released as received.
- DONE:
  - `out_valid_o`=1; outputs hold stable until accepted.
  - On `out_valid_o`&`out_ready_i`: go to WAIT_LOW if `core_ready_i`=1, else to IDLE.
- WAIT_LOW: go to IDLE when `core_ready_i`=0. This prevents re-capture from the same ready level.
- `core_ready_i` dropping in DONE or WAIT_LOW has no effect on held outputs.

## Timing
- Reset values: all outputs 0; state IDLE; `cnt`=0.
- `rst` mid-capture or in DONE: everything returns to reset values next edge; no `abort_o` pulse.
- Alignment: `core_ready_i` first sampled high in cycle R. The wrapper presents bit n in cycle R+1+n, which is when it is sampled.
- Last bit is sampled in cycle R+N. `out_valid_o` rises in cycle R+N+1; for Y=200 that is R+201.
- `out_valid_o` falls the cycle after the handshake.
- Minimum gap between handshake and the next capture start: 1 cycle (IDLE).
- `busy_o` is high for cycles R+1..R+N.
- Inputs `ser_*` are registered upstream; no combinational path from inputs to outputs.

## Test plan
- Encrypt, Y=200, T=128: serial stream data[n]=n[0], tag = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 LSB-first, `check_en`=0 -> `out_valid_o` at R+201, `out_data_o`={100{2'b10}}, `out_tag_o` equals the sent tag, `tag_ok_o`=0.
- Decrypt, matching `exp_tag` = sent tag -> `tag_ok_o`=1, `out_data_o` equals the sent data.
- Decrypt, `exp_tag` with bit 77 flipped -> `tag_ok_o`=0, `out_data_o`=0, `out_tag_o` equals the received tag.
- `core_ready_i` drops at SHIFT cycle 50 -> `abort_o`=1 for one cycle; IDLE; no `out_valid_o`. A full capture afterwards is correct.
- Backpressure: `out_ready_i`=0 for 10 cycles -> outputs stable, `out_valid_o` held. On accept with `core_ready_i` still high -> WAIT_LOW, no second capture until ready toggles low then high.
- `rst` asserted at SHIFT cycle 120 -> next cycle all outputs 0, IDLE. Capture restarts on the next `core_ready_i` rise.
